imp_var_std_unit: RTL and testbench



---
 rtl/imp_ln_pkg.sv | 20 ++
 rtl/imp_isqrt_seq.sv | 66 ++++++
 rtl/imp_var_std_unit.sv | 153 +++++++++++++++
 tb/tb_imp_var_std_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/imp_ln_pkg.sv
// Shared definitions for the improved LayerNorm statistics datapath.
// Holds the default datapath widths, the default epsilon and the
// state encoding of the variance / standard-deviation unit.
package imp_ln_pkg;

  localparam int EX_W    = 8;   // signed mean E[x]
  localparam int EX2_W   = 16;  // unsigned mean-square E[x^2]
  localparam int VAR_W   = 16;  // variance and square-root radicand
  localparam int STD_W   = 8;   // root width, VAR_W/2
  localparam int EPS_DEF = 1;   // epsilon added before the square root

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQ   = 3'd1,
    ST_SUB  = 3'd2,
    ST_SQRT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/imp_isqrt_seq.sv
// Sequential restoring integer square root, one result bit per cycle.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_start       load i_radicand and begin STD_W iterations
//   i_radicand    value whose floor square root is wanted
//   o_root        root as it stands after the current cycle's iteration;
//                 the final root when o_done is high
//   o_done        high during the cycle whose edge performs the last iteration
module imp_isqrt_seq #(
  parameter int VAR_W = imp_ln_pkg::VAR_W,
  parameter int STD_W = imp_ln_pkg::STD_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [VAR_W-1:0] i_radicand,
  output logic [STD_W-1:0] o_root,
  output logic             o_done
);

  localparam int CNT_W = $clog2(STD_W + 1);
  // The partial remainder never exceeds 2*root, so STD_W+1 bits hold it;
  // two extra bits absorb the pair shifted in each iteration.
  localparam int REM_W = STD_W + 3;

  logic [VAR_W-1:0] rad_q;
  logic [REM_W-1:0] rem_q;
  logic [STD_W-1:0] root_q;
  logic [CNT_W-1:0] cnt_q;

  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             take;
  logic [REM_W-1:0] rem_d;
  logic [STD_W-1:0] root_d;

  // Bring down the next two radicand bits and try subtracting 4*root+1.
  assign rem_sh = {rem_q[REM_W-3:0], rad_q[VAR_W-1 -: 2]};
  assign trial  = {1'b0, root_q, 2'b01};
  assign take   = (rem_sh >= trial);
  assign rem_d  = take ? (rem_sh - trial) : rem_sh;
  assign root_d = {root_q[STD_W-2:0], take};

  assign o_root = root_d;
  assign o_done = (cnt_q == CNT_W'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (i_start) begin
      rad_q  <= i_radicand;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CNT_W'(STD_W);
    end else if (cnt_q != '0) begin
      rad_q  <= rad_q << 2;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/imp_var_std_unit.sv
// Variance and standard-deviation stage of the improved LayerNorm datapath.
// Captures E[x] and E[x^2] in any order, computes Var = max(E[x^2]-E[x]^2, 0)
// and Std = floor(sqrt(min(Var+EPS, 2^VAR_W-1))), then pulses o_done.
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_Ex_done / i_Ex         one-cycle strobe with signed mean
//   i_Ex2_done / i_Ex2       one-cycle strobe with unsigned mean-square
//   o_busy                   high whenever the FSM is not idle
//   o_done                   one-cycle pulse, o_var / o_std updated
//   o_var, o_std             registered results, held until the next o_done
//   o_overrun                one-cycle pulse, a captured value was overwritten
// Handshake: each strobe is a valid without ready; a value is considered
// consumed only when the FSM leaves IDLE with it, so a second strobe before
// that overwrites it and raises o_overrun.
module imp_var_std_unit #(
  parameter int EX_W  = imp_ln_pkg::EX_W,
  parameter int EX2_W = imp_ln_pkg::EX2_W,
  parameter int VAR_W = imp_ln_pkg::VAR_W,
  parameter int STD_W = imp_ln_pkg::STD_W,
  parameter int EPS   = imp_ln_pkg::EPS_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_Ex_done,
  input  logic signed [EX_W-1:0]  i_Ex,
  input  logic                    i_Ex2_done,
  input  logic        [EX2_W-1:0] i_Ex2,
  output logic                    o_busy,
  output logic                    o_done,
  output logic        [VAR_W-1:0] o_var,
  output logic        [STD_W-1:0] o_std,
  output logic                    o_overrun
);

  import imp_ln_pkg::*;

  localparam logic [VAR_W-1:0] EPS_V = VAR_W'(EPS);

  state_e                  state_q;
  logic signed [EX_W-1:0]  hold_ex_q, ex_q;
  logic        [EX2_W-1:0] hold_ex2_q, ex2_q;
  logic                    ex_flag_q, ex2_flag_q;
  logic        [VAR_W-1:0] msq_q, var_q;
  logic        [VAR_W-1:0] var_out_q;
  logic        [STD_W-1:0] std_q;
  logic                    done_q, overrun_q;

  logic                      go;
  logic signed [2*EX_W-1:0]  ex_sq;
  logic        [VAR_W:0]     diff;
  logic        [VAR_W-1:0]   var_c;
  logic        [VAR_W:0]     rad_sum;
  logic        [VAR_W-1:0]   radicand;
  logic                      sq_start, sq_done;
  logic        [STD_W-1:0]   sq_root;

  assign go = (state_q == ST_IDLE) && ex_flag_q && ex2_flag_q;

  // Capture runs regardless of the FSM. On the consuming edge a new strobe
  // wins over the clear, so it is kept for the following round.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_ex_q  <= '0;
      hold_ex2_q <= '0;
      ex_flag_q  <= 1'b0;
      ex2_flag_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= !go && ((i_Ex_done && ex_flag_q) || (i_Ex2_done && ex2_flag_q));
      if (i_Ex_done) begin
        hold_ex_q <= i_Ex;
        ex_flag_q <= 1'b1;
      end else if (go) begin
        ex_flag_q <= 1'b0;
      end
      if (i_Ex2_done) begin
        hold_ex2_q <= i_Ex2;
        ex2_flag_q <= 1'b1;
      end else if (go) begin
        ex2_flag_q <= 1'b0;
      end
    end
  end

  // |E[x]| <= 128, so the square is at most 16384 and never negative.
  assign ex_sq    = ex_q * ex_q;
  assign diff     = {1'b0, VAR_W'(ex2_q)} - {1'b0, msq_q};
  assign var_c    = diff[VAR_W] ? '0 : diff[VAR_W-1:0];
  assign rad_sum  = {1'b0, var_c} + {1'b0, EPS_V};
  assign radicand = rad_sum[VAR_W] ? '1 : rad_sum[VAR_W-1:0];
  assign sq_start = (state_q == ST_SUB);

  imp_isqrt_seq #(
    .VAR_W (VAR_W),
    .STD_W (STD_W)
  ) u_isqrt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (sq_start),
    .i_radicand (radicand),
    .o_root     (sq_root),
    .o_done     (sq_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      ex_q      <= '0;
      ex2_q     <= '0;
      msq_q     <= '0;
      var_q     <= '0;
      var_out_q <= '0;
      std_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            ex_q    <= hold_ex_q;
            ex2_q   <= hold_ex2_q;
            state_q <= ST_SQ;
          end
        end
        ST_SQ: begin
          msq_q   <= VAR_W'(unsigned'(ex_sq));
          state_q <= ST_SUB;
        end
        ST_SUB: begin
          var_q   <= var_c;
          state_q <= ST_SQRT;
        end
        ST_SQRT: begin
          if (sq_done) begin
            var_out_q <= var_q;
            std_q     <= sq_root;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_q;
  assign o_var     = var_out_q;
  assign o_std     = std_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_imp_var_std_unit.sv
// Directed bench for imp_var_std_unit: a default build and an EPS=65535
// build share the same stimulus; each has its own expected-result queue.
module tb_imp_var_std_unit;

  logic               clk;
  logic               i_rst;
  logic               i_Ex_done;
  logic signed [7:0]  i_Ex;
  logic               i_Ex2_done;
  logic [15:0]        i_Ex2;
  logic               o_busy, o_done, o_overrun;
  logic [15:0]        o_var;
  logic [7:0]         o_std;
  logic               b_busy, b_done, b_overrun;
  logic [15:0]        b_var;
  logic [7:0]         b_std;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_a  = 0;
  int last_b  = 0;
  int e;

  // {var[15:0], std[7:0], done cycle[31:0]}; a zero cycle means
  // "12 cycles after the previous done".
  logic [55:0] exp_q[$];
  logic [55:0] exp2_q[$];
  logic [55:0] xa, xb;

  imp_var_std_unit dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_Ex_done(i_Ex_done), .i_Ex(i_Ex),
    .i_Ex2_done(i_Ex2_done), .i_Ex2(i_Ex2),
    .o_busy(o_busy), .o_done(o_done), .o_var(o_var), .o_std(o_std),
    .o_overrun(o_overrun)
  );

  imp_var_std_unit #(.EPS(65535)) dut_eps (
    .i_clk(clk), .i_rst(i_rst),
    .i_Ex_done(i_Ex_done), .i_Ex(i_Ex),
    .i_Ex2_done(i_Ex2_done), .i_Ex2(i_Ex2),
    .o_busy(b_busy), .o_done(b_done), .o_var(b_var), .o_std(b_std),
    .o_overrun(b_overrun)
  );

  // clock / cycle count
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [55:0] model(input int ex, input int ex2, input int eps, input int c);
    int v;
    int r;
    int s;
    v = ex2 - ex * ex;
    if (v < 0) v = 0;
    r = v + eps;
    if (r > 65535) r = 65535;
    s = 0;
    while ((s + 1) * (s + 1) <= r) s++;
    return {v[15:0], s[7:0], c[31:0]};
  endfunction

  task automatic push(input int ex, input int ex2, input int c);
    exp_q.push_back(model(ex, ex2, 1, c));
    exp2_q.push_back(model(ex, ex2, 65535, c));
  endtask

  // Drive strobes for one edge; returns the index of that edge.
  task automatic pulse(input bit dex, input logic signed [7:0] ex,
                       input bit dex2, input logic [15:0] ex2, output int edge_n);
    @(negedge clk);
    i_Ex_done  = dex;
    i_Ex       = ex;
    i_Ex2_done = dex2;
    i_Ex2      = ex2;
    edge_n     = cyc + 1;
    @(negedge clk);
    i_Ex_done  = 1'b0;
    i_Ex2_done = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (o_done) begin
      check("done_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        xa = exp_q.pop_front();
        check("var", o_var, xa[55:40]);
        check("std", o_std, xa[39:32]);
        check("latency", cyc, (xa[31:0] == 0) ? last_a + 12 : xa[31:0]);
      end
      last_a = cyc;
    end
    if (b_done) begin
      check("eps_done_expected", exp2_q.size() != 0, 1);
      if (exp2_q.size() != 0) begin
        xb = exp2_q.pop_front();
        check("eps_var", b_var, xb[55:40]);
        check("eps_std", b_std, xb[39:32]);
        check("eps_latency", cyc, (xb[31:0] == 0) ? last_b + 12 : xb[31:0]);
      end
      last_b = cyc;
    end
  end

  initial begin
    i_rst = 1'b1; i_Ex_done = 1'b0; i_Ex = '0; i_Ex2_done = 1'b0; i_Ex2 = '0;
    wait_cyc(2);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_var", o_var, 0);
    check("rst_std", o_std, 0);
    check("rst_overrun", o_overrun, 0);
    i_rst = 1'b0;
    wait_cyc(2);

    // both strobes together
    pulse(1, 3, 1, 25, e);
    push(3, 25, e + 11);
    check("t1_no_overrun", o_overrun, 0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("t1_busy", o_busy, 1);
    end
    @(negedge clk);
    check("t1_idle", o_busy, 0);
    check("t1_done_one_cycle", o_done, 0);

    // E[x^2] first, E[x] later
    pulse(0, 0, 1, 16384, e);
    check("t2_not_busy", o_busy, 0);
    wait_cyc(4);
    pulse(1, 0, 0, 0, e);
    push(0, 16384, e + 11);
    wait_cyc(13);

    // negative differences clamp to zero
    pulse(1, -4, 1, 10, e);
    push(-4, 10, e + 11);
    wait_cyc(13);
    pulse(1, -128, 1, 16384, e);
    push(-128, 16384, e + 11);
    wait_cyc(13);

    // look-ahead pair during SQRT, then an overwrite of E[x]
    pulse(1, 5, 1, 100, e);
    push(5, 100, e + 11);
    wait_cyc(4);
    pulse(1, 2, 1, 50, e);
    check("t5_no_overrun", o_overrun, 0);
    pulse(1, 6, 0, 0, e);
    check("t5_overrun", o_overrun, 1);
    check("t5_eps_overrun", b_overrun, 1);
    push(6, 50, 0);
    @(negedge clk);
    check("t5_overrun_pulse", o_overrun, 0);
    wait_cyc(20);

    // reset in the middle of the square root
    pulse(1, 7, 1, 60, e);
    wait_cyc(5);
    i_rst = 1'b1;
    #1;
    check("t6_busy", o_busy, 0);
    check("t6_done", o_done, 0);
    check("t6_var", o_var, 0);
    check("t6_std", o_std, 0);
    check("t6_overrun", o_overrun, 0);
    check("t6_eps_var", b_var, 0);
    check("t6_eps_std", b_std, 0);
    wait_cyc(2);
    i_rst = 1'b0;
    wait_cyc(15);
    check("t6_idle_after_rst", o_busy, 0);
    pulse(1, 0, 1, 0, e);
    push(0, 0, e + 11);
    wait_cyc(14);

    check("queue_drained", exp_q.size(), 0);
    check("eps_queue_drained", exp2_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
